dpll_loop_ctrl: RTL

- Loop controller for the DPLL core.
- Takes the phase-error direction from the JK-flip-flop phase detector (dn_up) and filters it in a modulo-K up/down counter (K-counter).
- K-counter overflow/underflow schedule pulse insertions/deletions in a toggling ID (increment/decrement) output, which feeds the loop divider.
- Also reports a lock indication.

---
 rtl/dpll_pkg.sv | 34 +++
 rtl/dpll_kcounter.sv | 53 +++++
 rtl/dpll_loop_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/dpll_pkg.sv
// Shared types and constants for the DPLL loop controller: ID half-period states,
// their lengths in clk cycles, and the request-queue ceiling.
package dpll_pkg;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    ADV  = 2'd1,
    RET  = 2'd2
  } id_state_e;

  localparam logic [1:0] HP_NORM  = 2'd2;
  localparam logic [1:0] HP_ADV   = 2'd1;
  localparam logic [1:0] HP_RET   = 2'd3;
  localparam logic [1:0] PEND_MAX = 2'd3;

  function automatic logic [1:0] hp_len(input id_state_e s);
    case (s)
      ADV:     hp_len = HP_ADV;
      RET:     hp_len = HP_RET;
      default: hp_len = HP_NORM;
    endcase
  endfunction

  // Queue depth after the FSM take and the carry/borrow update are summed
  function automatic logic [1:0] clamp_pend(input logic signed [3:0] v);
    if (v < 4'sd0)
      clamp_pend = 2'd0;
    else if (v > 4'sd3)
      clamp_pend = PEND_MAX;
    else
      clamp_pend = v[1:0];
  endfunction

endpackage

// File: rtl/dpll_kcounter.sv
// Modulo-K up/down counter filtering the phase-detector direction; emits registered
// one-cycle carry/borrow pulses on wrap, restarting from the midpoint.
module dpll_kcounter #(
  parameter int K_WIDTH = 8,
  parameter int K_MOD   = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_dn_up,
  output logic o_carry,
  output logic o_borrow
);

  localparam logic [K_WIDTH-1:0] K_MID = K_WIDTH'(K_MOD / 2);
  localparam logic [K_WIDTH-1:0] K_TOP = K_WIDTH'(K_MOD - 1);

  logic [K_WIDTH-1:0] r_kcnt;
  logic               r_carry;
  logic               r_borrow;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_kcnt   <= K_MID;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      if (i_en) begin
        if (!i_dn_up) begin
          if (r_kcnt == K_TOP) begin
            r_kcnt  <= K_MID;
            r_carry <= 1'b1;
          end else begin
            r_kcnt <= r_kcnt + 1'b1;
          end
        end else begin
          if (r_kcnt == '0) begin
            r_kcnt   <= K_MID;
            r_borrow <= 1'b1;
          end else begin
            r_kcnt <= r_kcnt - 1'b1;
          end
        end
      end
    end
  end

  assign o_carry  = r_carry;
  assign o_borrow = r_borrow;

endmodule

// File: rtl/dpll_loop_ctrl.sv
// DPLL loop controller: K-counter filter, saturating advance/retard request queue,
// ID output FSM with 1/2/3-cycle half-periods, and lock detection.
module dpll_loop_ctrl
  import dpll_pkg::*;
#(
  parameter int K_WIDTH  = 8,
  parameter int K_MOD    = 16,
  parameter int LOCK_WIN = 64,
  parameter int LOCK_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dn_up,
  output logic       carry,
  output logic       borrow,
  output logic       id_out,
  output logic [1:0] pend_inc,
  output logic [1:0] pend_dec,
  output logic       lock
);

  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_WIN);

  logic w_carry;
  logic w_borrow;

  dpll_kcounter #(
    .K_WIDTH(K_WIDTH),
    .K_MOD  (K_MOD)
  ) u_kcounter (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (en),
    .i_dn_up (dn_up),
    .o_carry (w_carry),
    .o_borrow(w_borrow)
  );

  id_state_e         r_state;
  logic [1:0]        r_ph;
  logic              r_id;
  logic [1:0]        r_pinc;
  logic [1:0]        r_pdec;
  logic [LOCK_W-1:0] r_lock_cnt;
  logic              r_lock;

  logic              w_boundary;
  logic              w_take_inc;
  logic              w_take_dec;
  id_state_e         w_next_state;
  logic signed [3:0] w_inc_sum;
  logic signed [3:0] w_dec_sum;
  logic [LOCK_W-1:0] w_lock_nxt;

  always_comb begin
    w_boundary   = (r_ph == hp_len(r_state) - 2'd1);
    w_take_inc   = w_boundary && (r_pinc != 2'd0);
    w_take_dec   = w_boundary && (r_pinc == 2'd0) && (r_pdec != 2'd0);
    w_next_state = w_take_inc ? ADV : (w_take_dec ? RET : NORM);

    // A carry first cancels a queued retard; only otherwise does it queue an advance
    w_inc_sum = signed'({2'b00, r_pinc});
    w_dec_sum = signed'({2'b00, r_pdec});
    if (w_take_inc) w_inc_sum = w_inc_sum - 4'sd1;
    if (w_take_dec) w_dec_sum = w_dec_sum - 4'sd1;
    if (w_carry) begin
      if (r_pdec != 2'd0) w_dec_sum = w_dec_sum - 4'sd1;
      else                w_inc_sum = w_inc_sum + 4'sd1;
    end
    if (w_borrow) begin
      if (r_pinc != 2'd0) w_inc_sum = w_inc_sum - 4'sd1;
      else                w_dec_sum = w_dec_sum + 4'sd1;
    end

    if (w_carry || w_borrow)
      w_lock_nxt = '0;
    else if (en && (r_lock_cnt != LOCK_MAX))
      w_lock_nxt = r_lock_cnt + 1'b1;
    else
      w_lock_nxt = r_lock_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= NORM;
      r_ph       <= 2'd0;
      r_id       <= 1'b0;
      r_pinc     <= 2'd0;
      r_pdec     <= 2'd0;
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_pinc     <= clamp_pend(w_inc_sum);
      r_pdec     <= clamp_pend(w_dec_sum);
      r_lock_cnt <= w_lock_nxt;
      r_lock     <= (w_lock_nxt == LOCK_MAX);
      if (w_boundary) begin
        r_id    <= ~r_id;
        r_ph    <= 2'd0;
        r_state <= w_next_state;
      end else begin
        r_ph <= r_ph + 2'd1;
      end
    end
  end

  assign carry    = w_carry;
  assign borrow   = w_borrow;
  assign id_out   = r_id;
  assign pend_inc = r_pinc;
  assign pend_dec = r_pdec;
  assign lock     = r_lock;

endmodule
